// File: rtl/playseq_exibidor_sequencia.sv
`default_nettype none
// ============================================================================
// Module      : playseq_exibidor_sequencia
// Description : Plays symbols 0..ultimo from a 16x4 sync-read sequence
//               memory onto one-hot LEDs. Each symbol is lit for T_ON
//               cycles and then followed by T_OFF dark cycles. A one-cycle
//               pronto pulse marks the end of the sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module playseq_exibidor_sequencia #(
  parameter int T_ON  = 500,  // cycles each symbol is lit, >= 1
  parameter int T_OFF = 250,  // dark cycles after each symbol, >= 1
  parameter int CNT_W = 10    // timer width, holds max(T_ON,T_OFF)-1
) (
  input  logic       clock,
  input  logic       reset,      // asynchronous, active-low
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] ultimo,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam logic [2:0] S_OCIOSO  = 3'd0;
  localparam logic [2:0] S_BUSCA   = 3'd1;
  localparam logic [2:0] S_ACESO   = 3'd2;
  localparam logic [2:0] S_APAGADO = 3'd3;
  localparam logic [2:0] S_FIM     = 3'd4;

  localparam logic [CNT_W-1:0] C_TON_LAST  = CNT_W'(T_ON - 1);
  localparam logic [CNT_W-1:0] C_TOFF_LAST = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  logic [2:0]       estado_q,   estado_d;
  logic [CNT_W-1:0] timer_q,    timer_d;
  logic [3:0]       endereco_q, endereco_d;
  logic [3:0]       leds_q,     leds_d;
  logic [3:0]       ultimo_q,   ultimo_d;
  logic             pronto_q,   pronto_d;
  logic             ocupado_q,  ocupado_d;

  // Next-state and next-output logic; outputs are computed from the next
  // state so that every output port comes straight from a register.
  always_comb begin
    estado_d   = estado_q;
    timer_d    = timer_q;
    endereco_d = endereco_q;
    leds_d     = leds_q;
    ultimo_d   = ultimo_q;
    pronto_d   = 1'b0;

    case (estado_q)
      S_OCIOSO: begin
        endereco_d = 4'd0;
        leds_d     = 4'd0;
        timer_d    = '0;
        if (iniciar) begin
          // The limit is frozen here; later changes of ultimo are ignored.
          ultimo_d = ultimo;
          estado_d = S_BUSCA;
        end
      end
      S_BUSCA: begin
        // Memory data for endereco is valid by the end of this cycle.
        leds_d   = dado;
        timer_d  = '0;
        estado_d = S_ACESO;
      end
      S_ACESO: begin
        if (timer_q == C_TON_LAST) begin
          timer_d  = '0;
          leds_d   = 4'd0;
          estado_d = S_APAGADO;
        end else begin
          timer_d = timer_q + C_ONE;
        end
      end
      S_APAGADO: begin
        if (timer_q == C_TOFF_LAST) begin
          timer_d = '0;
          if (endereco_q == ultimo_q) begin
            estado_d = S_FIM;
            pronto_d = 1'b1;
          end else begin
            // Never wraps: the compare above stops at ultimo <= 15.
            endereco_d = endereco_q + 4'd1;
            estado_d   = S_BUSCA;
          end
        end else begin
          timer_d = timer_q + C_ONE;
        end
      end
      S_FIM: begin
        endereco_d = 4'd0;
        leds_d     = 4'd0;
        estado_d   = S_OCIOSO;
      end
      default: begin
        endereco_d = 4'd0;
        leds_d     = 4'd0;
        timer_d    = '0;
        estado_d   = S_OCIOSO;
      end
    endcase

    // Abort overrides everything, including a simultaneous start request.
    if (abortar) begin
      estado_d   = S_OCIOSO;
      endereco_d = 4'd0;
      leds_d     = 4'd0;
      timer_d    = '0;
      pronto_d   = 1'b0;
    end

    ocupado_d = (estado_d != S_OCIOSO);
  end

  // State, timer and registered outputs with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= S_OCIOSO;
      timer_q    <= '0;
      endereco_q <= 4'd0;
      leds_q     <= 4'd0;
      ultimo_q   <= 4'd0;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      timer_q    <= timer_d;
      endereco_q <= endereco_d;
      leds_q     <= leds_d;
      ultimo_q   <= ultimo_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign endereco  = endereco_q;
  assign leds      = leds_q;
  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign db_estado = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_playseq_exibidor_sequencia.sv
`default_nettype none
// ============================================================================
// Module      : tb_playseq_exibidor_sequencia
// Description : Scoreboard bench for playseq_exibidor_sequencia with
//               T_ON=3, T_OFF=2 and a memory holding 1,2,4,8 repeating.
//               Stimulus pushes expected output events (with the edge count
//               at which they must appear); a negedge monitor pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playseq_exibidor_sequencia;

  localparam int TON  = 3;
  localparam int TOFF = 2;
  localparam int P    = 1 + TON + TOFF;

  localparam int K_BUSY   = 0;
  localparam int K_ADDR   = 1;
  localparam int K_LIT    = 2;
  localparam int K_DARK   = 3;
  localparam int K_PRONTO = 4;
  localparam int K_IDLE   = 5;

  typedef struct {
    int         kind;
    int         t;
    logic [3:0] val;
  } ev_t;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       abortar;
  logic [3:0] ultimo;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] mem [16];
  ev_t        sb[$];
  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         edge_cnt = 0;

  logic [3:0] p_leds = 4'd0;
  logic [3:0] p_end  = 4'd0;
  logic       p_ocup = 1'b0;
  logic       p_pr   = 1'b0;

  playseq_exibidor_sequencia #(
    .T_ON (TON),
    .T_OFF(TOFF),
    .CNT_W(10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .abortar  (abortar),
    .ultimo   (ultimo),
    .dado     (dado),
    .endereco (endereco),
    .leds     (leds),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Number of rising edges so far.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Memory model: data follows the address within the same cycle.
  always @(negedge clock) dado <= mem[endereco];

  task automatic push(input int kind, input int t, input logic [3:0] val);
    ev_t e;
    e.kind = kind;
    e.t    = t;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check(input int kind, input logic [3:0] val);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d t=%0d val=%b, required no event",
               kind, edge_cnt, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.t != edge_cnt || e.val != val) begin
        n_bad++;
        $display("FAIL event: got kind=%0d t=%0d val=%b, required kind=%0d t=%0d val=%b",
                 kind, edge_cnt, val, e.kind, e.t, e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: turn output changes into events and match them in order.
  always @(negedge clock) begin
    if (ocupado && !p_ocup)             check(K_BUSY, 4'd0);
    if (endereco != p_end)              check(K_ADDR, endereco);
    if (leds != 4'd0 && leds != p_leds) check(K_LIT, leds);
    if (leds == 4'd0 && p_leds != 4'd0) check(K_DARK, 4'd0);
    if (pronto && !p_pr)                check(K_PRONTO, 4'd0);
    if (pronto && p_pr) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pronto_width: got high 2+ cycles at t=%0d, required 1", edge_cnt);
    end
    if (!ocupado && p_ocup)             check(K_IDLE, 4'd0);
    p_leds = leds;
    p_end  = endereco;
    p_ocup = ocupado;
    p_pr   = pronto;
  end

  // Expected events of an uninterrupted run accepted at edge k.
  task automatic expect_run(input int k, input int ult);
    push(K_BUSY, k, 4'd0);
    for (int i = 0; i <= ult; i++) begin
      if (i > 0) push(K_ADDR, k + P*i, 4'(i));
      push(K_LIT,  k + P*i + 1,       4'(1 << (i % 4)));
      push(K_DARK, k + P*i + 1 + TON, 4'd0);
    end
    push(K_PRONTO, k + P*(ult+1), 4'd0);
    if (ult > 0) push(K_ADDR, k + P*(ult+1) + 1, 4'd0);
    push(K_IDLE, k + P*(ult+1) + 1, 4'd0);
  endtask

  // Issue a one-cycle start pulse; called at a negedge, returns at the
  // negedge just after the accepting edge k.
  task automatic start(input int ult, input bit full, output int k);
    ultimo  = 4'(ult);
    iniciar = 1'b1;
    k       = edge_cnt + 1;
    if (full) expect_run(k, ult);
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic go_to(input int t);
    while (edge_cnt < t) @(negedge clock);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d events still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    reset   = 1'b0;
    iniciar = 1'b0;
    abortar = 1'b0;
    ultimo  = 4'd0;
    #1;
    chk("reset_leds",     int'(leds),      0);
    chk("reset_endereco", int'(endereco),  0);
    chk("reset_ocupado",  int'(ocupado),   0);
    chk("reset_pronto",   int'(pronto),    0);
    chk("reset_estado",   int'(db_estado), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 1: four symbols
    start(3, 1'b1, k);
    chk("t1_estado_busca", int'(db_estado), 1);
    go_to(k + 1);
    chk("t1_estado_aceso", int'(db_estado), 2);
    go_to(k + 1 + TON);
    chk("t1_estado_apagado", int'(db_estado), 3);
    go_to(k + 4*P);
    chk("t1_estado_fim", int'(db_estado), 4);
    drain(200);
    chk("t1_ocupado_after", int'(ocupado), 0);

    // 2: single symbol
    start(0, 1'b1, k);
    drain(200);

    // 3: all sixteen symbols, no wrap
    start(15, 1'b1, k);
    drain(300);

    // 4: abort during the second lit phase
    start(3, 1'b0, k);
    push(K_BUSY, k,     4'd0);
    push(K_LIT,  k + 1, 4'd1);
    push(K_DARK, k + 4, 4'd0);
    push(K_ADDR, k + 6, 4'd1);
    push(K_LIT,  k + 7, 4'd2);
    push(K_ADDR, k + 9, 4'd0);
    push(K_DARK, k + 9, 4'd0);
    push(K_IDLE, k + 9, 4'd0);
    go_to(k + 8);
    abortar = 1'b1;
    @(negedge clock);
    abortar = 1'b0;
    drain(200);

    // 5: restart request and new limit mid-run are ignored
    start(3, 1'b1, k);
    go_to(k + 8);
    iniciar = 1'b1;
    ultimo  = 4'd7;
    @(negedge clock);
    iniciar = 1'b0;
    drain(200);

    // 6: asynchronous reset in the second dark phase
    start(3, 1'b0, k);
    push(K_BUSY, k,      4'd0);
    push(K_LIT,  k + 1,  4'd1);
    push(K_DARK, k + 4,  4'd0);
    push(K_ADDR, k + 6,  4'd1);
    push(K_LIT,  k + 7,  4'd2);
    push(K_DARK, k + 10, 4'd0);
    push(K_ADDR, k + 11, 4'd0);
    push(K_IDLE, k + 11, 4'd0);
    go_to(k + 10);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_endereco", int'(endereco), 0);
    chk("t6_async_ocupado",  int'(ocupado),  0);
    chk("t6_async_leds",     int'(leds),     0);
    chk("t6_async_pronto",   int'(pronto),   0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    drain(50);
    repeat (5) @(negedge clock);
    iniciar = 1'b1;
    abortar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    abortar = 1'b0;
    repeat (8) @(negedge clock);
    chk("t6_abort_wins_estado",  int'(db_estado), 0);
    chk("t6_abort_wins_ocupado", int'(ocupado),   0);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
